// File: rtl/router_input_buffer_if.sv
// Flit-side bundle of the router input buffer: upstream push, route lookup and switch handshake.
// master = upstream/switch side driving the buffer, slave = the buffer itself.
interface router_input_buffer_if #(
   parameter int FLIT_WIDTH = 37
);
   logic [FLIT_WIDTH-1:0] flit_req_i;
   logic                  flit_valid_i;
   logic                  flit_ready_o;
   logic [FLIT_WIDTH-1:0] head_flit_o;
   logic [4:0]            router_port_i;
   logic [FLIT_WIDTH-1:0] flit_o;
   logic                  flit_valid_o;
   logic                  flit_ready_i;
   logic [4:0]            route_req_o;
   logic                  err_o;

   modport master (
      output flit_req_i, flit_valid_i, router_port_i, flit_ready_i,
      input  flit_ready_o, head_flit_o, flit_o, flit_valid_o, route_req_o, err_o
   );

   modport slave (
      input  flit_req_i, flit_valid_i, router_port_i, flit_ready_i,
      output flit_ready_o, head_flit_o, flit_o, flit_valid_o, route_req_o, err_o
   );
endinterface

// File: rtl/router_input_buffer.sv
// Wormhole router input buffer: flit FIFO plus IDLE/LOCKED route-lock FSM.
// Optional macro ROUTE_ONEHOT_CHECK_EN: reject heads whose looked-up port is not one-hot (sticky err_o).
module router_input_buffer #(
   parameter int FLIT_WIDTH = 37,
   parameter int FIFO_DEPTH = 4
) (
   input logic                  clk,
   input logic                  arst,
   router_input_buffer_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   localparam logic [1:0] T_HEAD      = 2'b01;
   localparam logic [1:0] T_TAIL      = 2'b10;
   localparam logic [1:0] T_HEAD_TAIL = 2'b11;

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t                state, state_nxt;
   logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr, rd_ptr;
   logic [4:0]            route_lock;
   logic                  empty, full, push, pop, lock_en, out_fire;
   logic [1:0]            head_type;
   logic                  is_head, is_last;

   // Extra pointer bit separates full from empty when the index bits match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push  = bus.flit_valid_i & ~full & ~arst;

   assign bus.head_flit_o  = mem[rd_ptr[AW-1:0]];
   assign bus.flit_o       = mem[rd_ptr[AW-1:0]];
   assign bus.flit_ready_o = arst | ~full;
   assign bus.flit_valid_o = ~arst & (state == S_LOCKED) & ~empty;
   assign bus.route_req_o  = (~arst && state == S_LOCKED) ? route_lock : 5'd0;

   assign head_type = mem[rd_ptr[AW-1:0]][FLIT_WIDTH-1 -: 2];
   assign is_head   = (head_type == T_HEAD) || (head_type == T_HEAD_TAIL);
   assign is_last   = (head_type == T_TAIL) || (head_type == T_HEAD_TAIL);
   assign out_fire  = bus.flit_valid_o & bus.flit_ready_i;

`ifdef ROUTE_ONEHOT_CHECK_EN
   logic err_set, err_q;

   function automatic logic is_onehot(input logic [4:0] p);
      return (p != 5'd0) && ((p & (p - 5'd1)) == 5'd0);
   endfunction
`endif

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      lock_en   = 1'b0;
`ifdef ROUTE_ONEHOT_CHECK_EN
      err_set   = 1'b0;
`endif
      unique case (state)
         S_IDLE: begin
            if (!empty) begin
               if (is_head) begin
`ifdef ROUTE_ONEHOT_CHECK_EN
                  if (!is_onehot(bus.router_port_i)) begin
                     err_set = 1'b1;
                     pop     = 1'b1;
                  end else
`endif
                  begin
                     lock_en   = 1'b1;
                     state_nxt = S_LOCKED;
                  end
               end else begin
                  // Orphan body/tail with no route: drop it.
                  pop = 1'b1;
               end
            end
         end
         S_LOCKED: begin
            if (out_fire) begin
               pop = 1'b1;
               if (is_last) state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         route_lock <= '0;
      end else begin
         state <= state_nxt;
         if (push)    wr_ptr     <= wr_ptr + PTR_ONE;
         if (pop)     rd_ptr     <= rd_ptr + PTR_ONE;
         if (lock_en) route_lock <= bus.router_port_i;
      end
   end

   // Storage carries data only and is never reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= bus.flit_req_i;
   end

`ifdef ROUTE_ONEHOT_CHECK_EN
   always_ff @(posedge clk) begin
      if (arst)         err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
   end

   assign bus.err_o = err_q & ~arst;
`else
   assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_router_input_buffer.sv
// Self-checking bench for router_input_buffer: queue-based packet model checked every cycle,
// plus directed literal expectations for each packet scenario.
module tb_router_input_buffer;
   localparam int FW    = 37;
   localparam int DEPTH = 4;

   localparam logic [1:0] TY_BODY      = 2'b00;
   localparam logic [1:0] TY_HEAD      = 2'b01;
   localparam logic [1:0] TY_TAIL      = 2'b10;
   localparam logic [1:0] TY_HEAD_TAIL = 2'b11;

`ifdef ROUTE_ONEHOT_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic arst;
   always #5 clk = ~clk;

   router_input_buffer_if #(.FLIT_WIDTH(FW)) bus ();

   router_input_buffer #(.FLIT_WIDTH(FW), .FIFO_DEPTH(DEPTH)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [7:0] id);
      return {t, 27'h1234567, id};
   endfunction

   // Packet-level model: a flit queue, whether a route is held, which one, and the error flag.
   logic [FW-1:0] mq[$];
   bit            m_locked = 1'b0;
   logic [4:0]    m_lock   = 5'd0;
   bit            m_err    = 1'b0;
   bit            m_live   = 1'b0;

   always @(posedge clk) begin
      logic [FW-1:0] hd;
      logic [1:0]    t;
      bit            do_pop;
      bit            accept;
      if (arst) begin
         mq.delete();
         m_locked = 1'b0;
         m_lock   = 5'd0;
         m_err    = 1'b0;
         m_live   = 1'b1;
      end else if (m_live) begin
         do_pop = 1'b0;
         accept = bus.flit_valid_i && (mq.size() < DEPTH);
         if (mq.size() > 0) begin
            hd = mq[0];
            t  = hd[FW-1 -: 2];
            if (!m_locked) begin
               if (t == TY_HEAD || t == TY_HEAD_TAIL) begin
                  if (CHECK_EN && $countones(bus.router_port_i) != 1) begin
                     m_err  = 1'b1;
                     do_pop = 1'b1;
                  end else begin
                     m_locked = 1'b1;
                     m_lock   = bus.router_port_i;
                  end
               end else begin
                  do_pop = 1'b1;
               end
            end else if (bus.flit_ready_i) begin
               do_pop = 1'b1;
               if (t == TY_TAIL || t == TY_HEAD_TAIL) m_locked = 1'b0;
            end
         end
         if (do_pop) void'(mq.pop_front());
         if (accept) mq.push_back(bus.flit_req_i);
      end
   end

   always @(negedge clk) begin
      logic [4:0] exp_route;
      if (m_live) begin
         exp_route = (!arst && m_locked) ? m_lock : 5'd0;
         chk("m_ready", 64'(bus.flit_ready_o), 64'(arst || mq.size() < DEPTH));
         chk("m_valid", 64'(bus.flit_valid_o), 64'(!arst && m_locked && mq.size() > 0));
         chk("m_route", 64'(bus.route_req_o), 64'(exp_route));
         chk("m_err", 64'(bus.err_o), 64'(!arst && m_err));
         if (!arst && mq.size() > 0) begin
            chk("m_head_flit", 64'(bus.head_flit_o), 64'(mq[0]));
            chk("m_flit_o", 64'(bus.flit_o), 64'(mq[0]));
         end
      end
   end

   task automatic step(input logic v, input logic [FW-1:0] f, input logic [4:0] rp,
                       input logic rdy, input logic r);
      bus.flit_valid_i  = v;
      bus.flit_req_i    = f;
      bus.router_port_i = rp;
      bus.flit_ready_i  = rdy;
      arst              = r;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string name, input logic rdy, input logic vld,
                          input logic [4:0] route);
      chk({name, "_ready"}, 64'(bus.flit_ready_o), 64'(rdy));
      chk({name, "_valid"}, 64'(bus.flit_valid_o), 64'(vld));
      chk({name, "_route"}, 64'(bus.route_req_o), 64'(route));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a flit offered: it must not be stored.
      step(1'b1, mk(TY_HEAD, 8'h99), 5'b00100, 1'b1, 1'b1);
      step(1'b1, mk(TY_HEAD, 8'h99), 5'b00100, 1'b1, 1'b1);
      chk_out("rst", 1'b1, 1'b0, 5'd0);
      chk("rst_err", 64'(bus.err_o), 64'(0));
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);
      chk_out("rst_nostore", 1'b1, 1'b0, 5'd0);

      // Three-flit packet, switch always ready.
      step(1'b1, mk(TY_HEAD, 8'h11), 5'b00100, 1'b1, 1'b0);
      chk_out("p1_c1", 1'b1, 1'b0, 5'd0);
      step(1'b1, mk(TY_BODY, 8'h12), 5'b00100, 1'b1, 1'b0);
      chk_out("p1_c2", 1'b1, 1'b1, 5'b00100);
      chk("p1_c2_flit", 64'(bus.flit_o), 64'(mk(TY_HEAD, 8'h11)));
      step(1'b1, mk(TY_TAIL, 8'h13), 5'b01000, 1'b1, 1'b0);
      chk_out("p1_c3", 1'b1, 1'b1, 5'b00100);
      chk("p1_c3_flit", 64'(bus.flit_o), 64'(mk(TY_BODY, 8'h12)));
      step(1'b0, '0, 5'b01000, 1'b1, 1'b0);
      chk_out("p1_c4", 1'b1, 1'b1, 5'b00100);
      chk("p1_c4_flit", 64'(bus.flit_o), 64'(mk(TY_TAIL, 8'h13)));
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);
      chk_out("p1_c5", 1'b1, 1'b0, 5'd0);

      // Fill to capacity with the switch stalled.
      step(1'b1, mk(TY_HEAD, 8'h20), 5'b00010, 1'b0, 1'b0);
      step(1'b1, mk(TY_BODY, 8'h21), 5'b00010, 1'b0, 1'b0);
      step(1'b1, mk(TY_BODY, 8'h22), 5'd0, 1'b0, 1'b0);
      step(1'b1, mk(TY_BODY, 8'h23), 5'd0, 1'b0, 1'b0);
      chk_out("full_4", 1'b0, 1'b1, 5'b00010);
      step(1'b1, mk(TY_BODY, 8'h24), 5'd0, 1'b0, 1'b0);
      chk_out("full_5th", 1'b0, 1'b1, 5'b00010);
      chk("full_5th_flit", 64'(bus.flit_o), 64'(mk(TY_HEAD, 8'h20)));
      step(1'b1, mk(TY_BODY, 8'h25), 5'd0, 1'b1, 1'b0);
      chk_out("full_pop", 1'b1, 1'b1, 5'b00010);
      chk("full_pop_flit", 64'(bus.flit_o), 64'(mk(TY_BODY, 8'h21)));
      step(1'b1, mk(TY_BODY, 8'h25), 5'd0, 1'b1, 1'b0);
      chk_out("full_pushpop", 1'b1, 1'b1, 5'b00010);
      chk("full_pushpop_flit", 64'(bus.flit_o), 64'(mk(TY_BODY, 8'h22)));
      step(1'b1, mk(TY_TAIL, 8'h26), 5'd0, 1'b0, 1'b0);
      chk_out("full_refill", 1'b0, 1'b1, 5'b00010);
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);
      chk("drain_1", 64'(bus.flit_o), 64'(mk(TY_BODY, 8'h23)));
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);
      chk("drain_2", 64'(bus.flit_o), 64'(mk(TY_BODY, 8'h25)));
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);
      chk("drain_3", 64'(bus.flit_o), 64'(mk(TY_TAIL, 8'h26)));
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);
      chk_out("drain_end", 1'b1, 1'b0, 5'd0);

      // Orphan body and tail in IDLE are dropped.
      step(1'b1, mk(TY_BODY, 8'h30), 5'b00001, 1'b1, 1'b0);
      chk_out("orph_1", 1'b1, 1'b0, 5'd0);
      step(1'b1, mk(TY_TAIL, 8'h31), 5'b00001, 1'b1, 1'b0);
      chk_out("orph_2", 1'b1, 1'b0, 5'd0);
      step(1'b0, '0, 5'b00001, 1'b1, 1'b0);
      chk_out("orph_3", 1'b1, 1'b0, 5'd0);
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);

      // Single-flit packet followed immediately by a new head.
      step(1'b1, mk(TY_HEAD_TAIL, 8'h40), 5'b10000, 1'b1, 1'b0);
      chk_out("ht_c1", 1'b1, 1'b0, 5'd0);
      step(1'b1, mk(TY_HEAD, 8'h41), 5'b10000, 1'b1, 1'b0);
      chk_out("ht_c2", 1'b1, 1'b1, 5'b10000);
      chk("ht_c2_flit", 64'(bus.flit_o), 64'(mk(TY_HEAD_TAIL, 8'h40)));
      step(1'b1, mk(TY_TAIL, 8'h42), 5'b00001, 1'b1, 1'b0);
      chk_out("ht_c3", 1'b1, 1'b0, 5'd0);
      step(1'b0, '0, 5'b00001, 1'b1, 1'b0);
      chk_out("ht_c4", 1'b1, 1'b1, 5'b00001);
      chk("ht_c4_flit", 64'(bus.flit_o), 64'(mk(TY_HEAD, 8'h41)));
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);
      chk("ht_c5_flit", 64'(bus.flit_o), 64'(mk(TY_TAIL, 8'h42)));
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);
      chk_out("ht_c6", 1'b1, 1'b0, 5'd0);

      // Lock is held while the FIFO runs dry mid-packet.
      step(1'b1, mk(TY_HEAD, 8'h50), 5'b01000, 1'b1, 1'b0);
      step(1'b0, '0, 5'b01000, 1'b1, 1'b0);
      chk_out("dry_c2", 1'b1, 1'b1, 5'b01000);
      step(1'b0, '0, 5'b00001, 1'b1, 1'b0);
      chk_out("dry_c3", 1'b1, 1'b0, 5'b01000);
      step(1'b0, '0, 5'b00001, 1'b1, 1'b0);
      chk_out("dry_c4", 1'b1, 1'b0, 5'b01000);
      step(1'b1, mk(TY_TAIL, 8'h51), 5'd0, 1'b1, 1'b0);
      chk_out("dry_c5", 1'b1, 1'b1, 5'b01000);
      chk("dry_c5_flit", 64'(bus.flit_o), 64'(mk(TY_TAIL, 8'h51)));
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);
      chk_out("dry_c6", 1'b1, 1'b0, 5'd0);

      // Reset in the middle of a packet, then a fresh head.
      step(1'b1, mk(TY_HEAD, 8'h60), 5'b00010, 1'b0, 1'b0);
      step(1'b1, mk(TY_BODY, 8'h61), 5'b00010, 1'b0, 1'b0);
      chk_out("mid_locked", 1'b1, 1'b1, 5'b00010);
      step(1'b1, mk(TY_BODY, 8'h62), 5'b00010, 1'b0, 1'b1);
      chk_out("mid_rst", 1'b1, 1'b0, 5'd0);
      step(1'b1, mk(TY_HEAD, 8'h63), 5'b00001, 1'b1, 1'b0);
      chk_out("mid_new_c1", 1'b1, 1'b0, 5'd0);
      step(1'b0, '0, 5'b00001, 1'b1, 1'b0);
      chk_out("mid_new_c2", 1'b1, 1'b1, 5'b00001);
      chk("mid_new_flit", 64'(bus.flit_o), 64'(mk(TY_HEAD, 8'h63)));
      step(1'b1, mk(TY_TAIL, 8'h64), 5'd0, 1'b1, 1'b0);
      chk("mid_tail_flit", 64'(bus.flit_o), 64'(mk(TY_TAIL, 8'h64)));
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);
      chk_out("mid_end", 1'b1, 1'b0, 5'd0);

      // Head routed to a non-one-hot port.
      step(1'b1, mk(TY_HEAD, 8'h70), 5'b00110, 1'b1, 1'b0);
      step(1'b1, mk(TY_BODY, 8'h71), 5'b00110, 1'b1, 1'b0);
`ifdef ROUTE_ONEHOT_CHECK_EN
      chk_out("oh_c2", 1'b1, 1'b0, 5'd0);
      chk("oh_c2_err", 64'(bus.err_o), 64'(1));
      step(1'b1, mk(TY_TAIL, 8'h72), 5'd0, 1'b1, 1'b0);
      chk_out("oh_c3", 1'b1, 1'b0, 5'd0);
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);
      chk_out("oh_c5", 1'b1, 1'b0, 5'd0);
      chk("oh_c5_err", 64'(bus.err_o), 64'(1));
`else
      chk_out("oh_c2", 1'b1, 1'b1, 5'b00110);
      chk("oh_c2_err", 64'(bus.err_o), 64'(0));
      step(1'b1, mk(TY_TAIL, 8'h72), 5'd0, 1'b1, 1'b0);
      chk("oh_c3_flit", 64'(bus.flit_o), 64'(mk(TY_BODY, 8'h71)));
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);
      chk_out("oh_c5", 1'b1, 1'b0, 5'd0);
      chk("oh_c5_err", 64'(bus.err_o), 64'(0));
`endif
      step(1'b0, '0, 5'd0, 1'b1, 1'b1);
      chk("oh_rst_err", 64'(bus.err_o), 64'(0));
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);
      step(1'b0, '0, 5'd0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
